treino_ctrl: RTL and testbench
==============================

TREINO_CTRL -- requirements
Module: treino_ctrl

Interface
REQ-001 Parameter TAM, 16, word width; all weight, sample and rate values are IEEE-754 half precision.
REQ-002 Parameter LAT, 2, settle cycles allowed for the combinational epoch datapath per sample; legal range 1..15.
REQ-003 Parameter MAX_EPOCAS, 8'd50, epoch limit before abandoning training; legal range 1..255.
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a training run; sampled only in IDLE.
REQ-007 u_in  input  TAM  learning rate, captured on accepted start.
REQ-008 w0_init, w1_init, w2_init  input  TAM each  initial weights, captured on accepted start.
REQ-009 result  input  TAM  datapath output y for the current sample.
REQ-010 w0_new, w1_new, w2_new  input  TAM each  datapath-updated weights for the current sample.
REQ-011 in1, in2, d  output  TAM each  current sample inputs and desired output, driven to the datapath.
REQ-012 u  output  TAM  captured learning rate, driven to the datapath.
REQ-013 w0, w1, w2  output  TAM each  registered current weights, driven to the datapath.
REQ-014 busy  output  1  high from the cycle after an accepted start through CHECK inclusive.
REQ-015 done  output  1  one-cycle pulse at end of a run.
REQ-016 converged  output  1  valid with done and held until next accepted start; 1 = epoch with zero errors reached.
REQ-017 epoch_cnt  output  8  epochs completed in the current/last run.
REQ-018 err_cnt  output  3  error count of the most recently completed epoch.

Function
REQ-019 Training set SHALL be the fixed OR table, indexed 0..3: (in1,in2,d) = (0,0,0), (0,1,1), (1,0,1), (1,1,1); 0 encoded 16'h0000, 1 encoded 16'h3C00.
REQ-020 FSM states SHALL be IDLE, LOAD, APPLY, EVAL, CHECK, DONE.
REQ-021 IDLE: start=1 -> LOAD; start ignored in every other state.
REQ-022 LOAD (1 cycle): register u_in and w*_init; clear sample index, running error counter, epoch_cnt, converged; -> APPLY.
REQ-023 APPLY: drive sample[index]; hold for exactly LAT cycles via settle counter; -> EVAL.
REQ-024 EVAL (1 cycle): error = (result != d) as exact 16-bit compare; on error load w0..w2 from w*_new and increment running error counter; on no error weights unchanged.
REQ-025 EVAL exit: index<3 -> increment index, -> APPLY; index=3 -> CHECK.
REQ-026 CHECK (1 cycle): err_cnt <= running count; epoch_cnt <= epoch_cnt+1; running count cleared; index cleared.
REQ-027 CHECK exit: running count 0 -> DONE with converged<=1; else epoch_cnt+1 = MAX_EPOCAS -> DONE with converged<=0; else -> APPLY.
REQ-028 DONE (1 cycle): done=1; -> IDLE; weights, epoch_cnt, err_cnt, converged held until next accepted start.
REQ-029 Each epoch SHALL take 4*(LAT+1)+1 cycles; a run of E epochs SHALL assert done exactly 1+E*(4*(LAT+1)+1)+1 cycles after the start-accepting edge.
REQ-030 in1, in2, d SHALL be 16'h0000 outside APPLY/EVAL.
REQ-031 epoch_cnt SHALL saturate at MAX_EPOCAS and never wrap.

Reset
REQ-032 On reset: state IDLE; busy, done, converged=0; epoch_cnt, err_cnt, index, counters=0; w0..w2, u, in1, in2, d=16'h0000.
REQ-033 Reset SHALL take priority over start and abort any run mid-operation with no done pulse.

Verification
REQ-034 Stub datapath result=d, LAT=2, start pulse -> done 15 cycles after start edge, converged=1, epoch_cnt=1, err_cnt=0, weights = init values.
REQ-035 Stub result=16'h0000, w*_new=w*+1, MAX_EPOCAS=3, init weights 0 -> done after 3 epochs (41 cycles), converged=0, epoch_cnt=3, err_cnt=3, w0=w1=w2=16'h0009.
REQ-036 Check sample sequence per epoch: in1/in2/d each held LAT cycles plus EVAL in order 0,1,2,3, values per REQ-019.
REQ-037 Reset asserted during APPLY of epoch 2 -> next cycle all outputs per REQ-032, no done pulse.
REQ-038 start held high continuously -> start ignored while busy; a new run begins only on the cycle after DONE returns to IDLE.
REQ-039 Stub erring only on sample 0 in epoch 1, then result=d -> converged=1, epoch_cnt=2, err_cnt=0, one weight update.

Source files
------------

// File: rtl/treino_ctrl_if.sv
// Bus between the perceptron training controller and its datapath/host.
// The host drives start, learning rate and initial weights; the datapath
// returns its output and updated weights. The controller drives the rest.
interface treino_ctrl_if #(
    parameter int TAM = 16
);
    logic           start;
    logic [TAM-1:0] u_in;
    logic [TAM-1:0] w0_init;
    logic [TAM-1:0] w1_init;
    logic [TAM-1:0] w2_init;
    logic [TAM-1:0] result;
    logic [TAM-1:0] w0_new;
    logic [TAM-1:0] w1_new;
    logic [TAM-1:0] w2_new;

    logic [TAM-1:0] in1;
    logic [TAM-1:0] in2;
    logic [TAM-1:0] d;
    logic [TAM-1:0] u;
    logic [TAM-1:0] w0;
    logic [TAM-1:0] w1;
    logic [TAM-1:0] w2;
    logic           busy;
    logic           done;
    logic           converged;
    logic [7:0]     epoch_cnt;
    logic [2:0]     err_cnt;

    // Host / datapath side
    modport master (
        output start, u_in, w0_init, w1_init, w2_init,
        output result, w0_new, w1_new, w2_new,
        input  in1, in2, d, u, w0, w1, w2,
        input  busy, done, converged, epoch_cnt, err_cnt
    );

    // Controller side
    modport slave (
        input  start, u_in, w0_init, w1_init, w2_init,
        input  result, w0_new, w1_new, w2_new,
        output in1, in2, d, u, w0, w1, w2,
        output busy, done, converged, epoch_cnt, err_cnt
    );
endinterface

// File: rtl/treino_ctrl.sv
// Training controller for a 2-input perceptron learning the OR function.
// It walks the four OR samples once per epoch, lets the external datapath
// settle for LAT cycles per sample, applies the datapath's weight update
// whenever the output differs from the target, and stops either on an
// error-free epoch (converged) or after MAX_EPOCAS epochs (abandoned).
module treino_ctrl #(
    parameter int         TAM        = 16,
    parameter int         LAT        = 2,
    parameter logic [7:0] MAX_EPOCAS = 8'd50
) (
    input  logic         clk,
    input  logic         reset,
    treino_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] APPLY = 3'd2;
    localparam logic [2:0] EVAL  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [TAM-1:0] HALF_ZERO = '0;
    localparam logic [TAM-1:0] HALF_ONE  = TAM'(16'h3C00);
    localparam logic [3:0]     LAT_LAST  = 4'(LAT - 1);

    logic [2:0]     state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     settle_q, settle_d;
    logic [2:0]     run_err_q, run_err_d;
    logic [7:0]     epoch_cnt_q, epoch_cnt_d;
    logic [2:0]     err_cnt_q, err_cnt_d;
    logic           converged_q, converged_d;
    logic [TAM-1:0] u_q, u_d;
    logic [TAM-1:0] w0_q, w0_d;
    logic [TAM-1:0] w1_q, w1_d;
    logic [TAM-1:0] w2_q, w2_d;

    logic [TAM-1:0] smp_in1, smp_in2, smp_d;
    logic           sample_err;
    logic           last_epoch;

    // Present the current OR sample only while it is being applied/evaluated
    always_comb begin
        smp_in1 = HALF_ZERO;
        smp_in2 = HALF_ZERO;
        smp_d   = HALF_ZERO;
        if (state_q == APPLY || state_q == EVAL) begin
            smp_in1 = idx_q[1] ? HALF_ONE : HALF_ZERO;
            smp_in2 = idx_q[0] ? HALF_ONE : HALF_ZERO;
            smp_d   = (idx_q != 2'd0) ? HALF_ONE : HALF_ZERO;
        end
    end

    assign sample_err = (bus.result != smp_d);
    assign last_epoch = (({1'b0, epoch_cnt_q} + 9'd1) == {1'b0, MAX_EPOCAS});

    // Next-state and datapath-register update for the training sequence
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        run_err_d   = run_err_q;
        epoch_cnt_d = epoch_cnt_q;
        err_cnt_d   = err_cnt_q;
        converged_d = converged_q;
        u_d         = u_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                u_d         = bus.u_in;
                w0_d        = bus.w0_init;
                w1_d        = bus.w1_init;
                w2_d        = bus.w2_init;
                idx_d       = 2'd0;
                settle_d    = 4'd0;
                run_err_d   = 3'd0;
                epoch_cnt_d = 8'd0;
                converged_d = 1'b0;
                state_d     = APPLY;
            end
            APPLY: begin
                if (settle_q == LAT_LAST) begin
                    settle_d = 4'd0;
                    state_d  = EVAL;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            EVAL: begin
                if (sample_err) begin
                    w0_d      = bus.w0_new;
                    w1_d      = bus.w1_new;
                    w2_d      = bus.w2_new;
                    run_err_d = run_err_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    state_d = CHECK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = APPLY;
                end
            end
            CHECK: begin
                err_cnt_d = run_err_q;
                if (epoch_cnt_q != MAX_EPOCAS) begin
                    epoch_cnt_d = epoch_cnt_q + 8'd1;
                end
                run_err_d = 3'd0;
                idx_d     = 2'd0;
                if (run_err_q == 3'd0) begin
                    converged_d = 1'b1;
                    state_d     = DONE;
                end else if (last_epoch) begin
                    converged_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run and clears every output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            settle_q    <= 4'd0;
            run_err_q   <= 3'd0;
            epoch_cnt_q <= 8'd0;
            err_cnt_q   <= 3'd0;
            converged_q <= 1'b0;
            u_q         <= HALF_ZERO;
            w0_q        <= HALF_ZERO;
            w1_q        <= HALF_ZERO;
            w2_q        <= HALF_ZERO;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            run_err_q   <= run_err_d;
            epoch_cnt_q <= epoch_cnt_d;
            err_cnt_q   <= err_cnt_d;
            converged_q <= converged_d;
            u_q         <= u_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
        end
    end

    assign bus.in1       = smp_in1;
    assign bus.in2       = smp_in2;
    assign bus.d         = smp_d;
    assign bus.u         = u_q;
    assign bus.w0        = w0_q;
    assign bus.w1        = w1_q;
    assign bus.w2        = w2_q;
    assign bus.busy      = (state_q == LOAD) || (state_q == APPLY) ||
                           (state_q == EVAL) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.converged = converged_q;
    assign bus.epoch_cnt = epoch_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_treino_ctrl.sv
// Bench for treino_ctrl: two instances (epoch limits 50 and 3) share one
// host stimulus; each has its own stub datapath whose errors follow a
// per-epoch/per-sample table. Expected results come from an epoch-level
// model of the training rules and a cycle-position timing model.
module tb_treino_ctrl;

    localparam int          LAT   = 2;
    localparam int          SLOT  = LAT + 1;
    localparam int          EP    = 4 * SLOT + 1;
    localparam int          MAX_A = 50;
    localparam int          MAX_B = 3;
    localparam logic [15:0] ONE   = 16'h3C00;

    logic clk;
    logic reset;

    int total;
    int bad;

    logic        err_tab [0:7][0:3];
    logic [15:0] inc0, inc1, inc2;
    logic [15:0] init0, init1, init2, u_val;

    logic [15:0] or_in1 [0:3];
    logic [15:0] or_in2 [0:3];
    logic [15:0] or_d   [0:3];

    treino_ctrl_if #(.TAM(16)) bus_a ();
    treino_ctrl_if #(.TAM(16)) bus_b ();

    treino_ctrl #(.TAM(16), .LAT(LAT), .MAX_EPOCAS(8'(MAX_A))) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    treino_ctrl #(.TAM(16), .LAT(LAT), .MAX_EPOCAS(8'(MAX_B))) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Stub datapath for instance A: err_tab decides a wrong output per sample
    always_comb begin
        int s;
        int row;
        s   = ((bus_a.in1 == ONE) ? 2 : 0) + ((bus_a.in2 == ONE) ? 1 : 0);
        row = (bus_a.epoch_cnt > 8'd7) ? 7 : int'(bus_a.epoch_cnt);
        bus_a.result = err_tab[row][s] ? (bus_a.d ^ ONE) : bus_a.d;
        bus_a.w0_new = bus_a.w0 + inc0;
        bus_a.w1_new = bus_a.w1 + inc1;
        bus_a.w2_new = bus_a.w2 + inc2;
    end

    // Stub datapath for instance B, same rules
    always_comb begin
        int s;
        int row;
        s   = ((bus_b.in1 == ONE) ? 2 : 0) + ((bus_b.in2 == ONE) ? 1 : 0);
        row = (bus_b.epoch_cnt > 8'd7) ? 7 : int'(bus_b.epoch_cnt);
        bus_b.result = err_tab[row][s] ? (bus_b.d ^ ONE) : bus_b.d;
        bus_b.w0_new = bus_b.w0 + inc0;
        bus_b.w1_new = bus_b.w1 + inc1;
        bus_b.w2_new = bus_b.w2 + inc2;
    end

    // Epoch-level model: run epochs until an error-free one or the limit
    task automatic model(input int max_ep, output int ep, output int ec,
                         output logic conv, output logic [15:0] m0,
                         output logic [15:0] m1, output logic [15:0] m2);
        int cnt;
        m0 = init0; m1 = init1; m2 = init2;
        ep = 0; ec = 0; conv = 1'b0;
        for (int e = 0; e < 1000; e++) begin
            cnt = 0;
            for (int s = 0; s < 4; s++) begin
                if (err_tab[(e < 7) ? e : 7][s]) begin
                    cnt++;
                    m0 = m0 + inc0; m1 = m1 + inc1; m2 = m2 + inc2;
                end
            end
            ep = e + 1;
            ec = cnt;
            if (cnt == 0) begin
                conv = 1'b1;
                break;
            end
            if (ep == max_ep) begin
                conv = 1'b0;
                break;
            end
        end
    endtask

    // Timing model: cycle k after the accepting edge (k=1 is the load cycle)
    task automatic exp_cycle(input int k, input int n_ep, output logic eb,
                             output logic ed, output logic [15:0] e1,
                             output logic [15:0] e2, output logic [15:0] edd);
        int p;
        eb = 1'b0; ed = 1'b0; e1 = '0; e2 = '0; edd = '0;
        if (k == 1) begin
            eb = 1'b1;
        end else if (k >= 2 && k <= 1 + EP * n_ep) begin
            eb = 1'b1;
            p  = (k - 2) % EP;
            if (p < 4 * SLOT) begin
                e1  = or_in1[p / SLOT];
                e2  = or_in2[p / SLOT];
                edd = or_d[p / SLOT];
            end
        end else if (k == 2 + EP * n_ep) begin
            ed = 1'b1;
        end
    endtask

    task automatic drive_start(input logic v);
        bus_a.start   = v;       bus_b.start   = v;
        bus_a.u_in    = u_val;   bus_b.u_in    = u_val;
        bus_a.w0_init = init0;   bus_b.w0_init = init0;
        bus_a.w1_init = init1;   bus_b.w1_init = init1;
        bus_a.w2_init = init2;   bus_b.w2_init = init2;
    endtask

    task automatic clear_tab();
        for (int e = 0; e < 8; e++)
            for (int s = 0; s < 4; s++)
                err_tab[e][s] = 1'b0;
    endtask

    // Run one training on both instances, checking every cycle and the end state
    task automatic run_and_check(input string name);
        int ep_a, ec_a, ep_b, ec_b, last;
        logic cv_a, cv_b;
        logic [15:0] a0, a1, a2, b0, b1, b2;
        logic eb, ed;
        logic [15:0] e1, e2, edd;
        model(MAX_A, ep_a, ec_a, cv_a, a0, a1, a2);
        model(MAX_B, ep_b, ec_b, cv_b, b0, b1, b2);
        last = 2 + EP * ((ep_a > ep_b) ? ep_a : ep_b) + 2;
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        for (int k = 1; k <= last; k++) begin
            exp_cycle(k, ep_a, eb, ed, e1, e2, edd);
            total++;
            if ({bus_a.busy, bus_a.done, bus_a.in1, bus_a.in2, bus_a.d} !== {eb, ed, e1, e2, edd}) begin
                bad++;
                $display("[TB] FAIL %s_cycle_a k=%0d got busy=%b done=%b in=%h/%h/%h want busy=%b done=%b in=%h/%h/%h",
                         name, k, bus_a.busy, bus_a.done, bus_a.in1, bus_a.in2, bus_a.d, eb, ed, e1, e2, edd);
            end
            exp_cycle(k, ep_b, eb, ed, e1, e2, edd);
            total++;
            if ({bus_b.busy, bus_b.done, bus_b.in1, bus_b.in2, bus_b.d} !== {eb, ed, e1, e2, edd}) begin
                bad++;
                $display("[TB] FAIL %s_cycle_b k=%0d got busy=%b done=%b in=%h/%h/%h want busy=%b done=%b in=%h/%h/%h",
                         name, k, bus_b.busy, bus_b.done, bus_b.in1, bus_b.in2, bus_b.d, eb, ed, e1, e2, edd);
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus_a.converged, bus_a.epoch_cnt, bus_a.err_cnt} !== {cv_a, 8'(ep_a), 3'(ec_a)}) begin
            bad++;
            $display("[TB] FAIL %s_status_a got conv=%b ep=%0d err=%0d want conv=%b ep=%0d err=%0d",
                     name, bus_a.converged, bus_a.epoch_cnt, bus_a.err_cnt, cv_a, ep_a, ec_a);
        end
        total++;
        if ({bus_a.w0, bus_a.w1, bus_a.w2, bus_a.u} !== {a0, a1, a2, u_val}) begin
            bad++;
            $display("[TB] FAIL %s_weights_a got %h %h %h u=%h want %h %h %h u=%h",
                     name, bus_a.w0, bus_a.w1, bus_a.w2, bus_a.u, a0, a1, a2, u_val);
        end
        total++;
        if ({bus_b.converged, bus_b.epoch_cnt, bus_b.err_cnt} !== {cv_b, 8'(ep_b), 3'(ec_b)}) begin
            bad++;
            $display("[TB] FAIL %s_status_b got conv=%b ep=%0d err=%0d want conv=%b ep=%0d err=%0d",
                     name, bus_b.converged, bus_b.epoch_cnt, bus_b.err_cnt, cv_b, ep_b, ec_b);
        end
        total++;
        if ({bus_b.w0, bus_b.w1, bus_b.w2, bus_b.u} !== {b0, b1, b2, u_val}) begin
            bad++;
            $display("[TB] FAIL %s_weights_b got %h %h %h u=%h want %h %h %h u=%h",
                     name, bus_b.w0, bus_b.w1, bus_b.w2, bus_b.u, b0, b1, b2, u_val);
        end
    endtask

    // Reset wins over start; every output cleared
    task automatic test_reset();
        reset = 1'b1;
        u_val = 16'h1234; init0 = 16'h1111; init1 = 16'h2222; init2 = 16'h3333;
        drive_start(1'b1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_a.busy, bus_a.done, bus_a.converged, bus_a.epoch_cnt, bus_a.err_cnt,
             bus_a.w0, bus_a.w1, bus_a.w2, bus_a.u, bus_a.in1, bus_a.in2, bus_a.d} !== 126'd0) begin
            bad++;
            $display("[TB] FAIL reset_a got busy=%b done=%b ep=%0d w0=%h u=%h", bus_a.busy, bus_a.done,
                     bus_a.epoch_cnt, bus_a.w0, bus_a.u);
        end
        total++;
        if ({bus_b.busy, bus_b.done, bus_b.converged, bus_b.epoch_cnt, bus_b.err_cnt,
             bus_b.w0, bus_b.w1, bus_b.w2, bus_b.u, bus_b.in1, bus_b.in2, bus_b.d} !== 126'd0) begin
            bad++;
            $display("[TB] FAIL reset_b got busy=%b done=%b ep=%0d w0=%h u=%h", bus_b.busy, bus_b.done,
                     bus_b.epoch_cnt, bus_b.w0, bus_b.u);
        end
        drive_start(1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Datapath always right: converges after one epoch, weights untouched
    task automatic test_converge_first();
        clear_tab();
        inc0 = 16'h0001; inc1 = 16'h0002; inc2 = 16'h0003;
        u_val = 16'h2E66; init0 = 16'hBC00; init1 = 16'h3800; init2 = 16'h4000;
        run_and_check("converge_first");
    endtask

    // Datapath output stuck at 0: three errors every epoch until the limit
    task automatic test_max_epochs();
        clear_tab();
        for (int e = 0; e < 8; e++)
            for (int s = 1; s < 4; s++)
                err_tab[e][s] = 1'b1;
        inc0 = 16'h0001; inc1 = 16'h0001; inc2 = 16'h0001;
        u_val = 16'h3C00; init0 = 16'h0000; init1 = 16'h0000; init2 = 16'h0000;
        run_and_check("max_epochs");
        total++;
        if ({bus_b.w0, bus_b.w1, bus_b.w2, bus_b.epoch_cnt, bus_b.err_cnt} !==
            {16'h0009, 16'h0009, 16'h0009, 8'd3, 3'd3}) begin
            bad++;
            $display("[TB] FAIL max_epochs_abs got w=%h %h %h ep=%0d err=%0d want w=0009 ep=3 err=3",
                     bus_b.w0, bus_b.w1, bus_b.w2, bus_b.epoch_cnt, bus_b.err_cnt);
        end
    endtask

    // Single error on sample 0 of the first epoch, then clean
    task automatic test_one_error();
        clear_tab();
        err_tab[0][0] = 1'b1;
        inc0 = 16'h0100; inc1 = 16'h0010; inc2 = 16'h0001;
        u_val = 16'h3400; init0 = 16'h3C00; init1 = 16'h0000; init2 = 16'hC000;
        run_and_check("one_error");
    endtask

    // Random error patterns that clear after a few epochs, random weights
    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear_tab();
            for (int e = 0; e < 4; e++)
                for (int s = 0; s < 4; s++)
                    err_tab[e][s] = 1'($urandom_range(0, 1));
            inc0 = 16'($urandom); inc1 = 16'($urandom); inc2 = 16'($urandom);
            u_val = 16'($urandom); init0 = 16'($urandom);
            init1 = 16'($urandom); init2 = 16'($urandom);
            run_and_check($sformatf("random%0d", it));
        end
    endtask

    // Reset during APPLY of epoch 2 clears everything and suppresses done
    task automatic test_reset_mid();
        clear_tab();
        for (int e = 0; e < 8; e++)
            for (int s = 1; s < 4; s++)
                err_tab[e][s] = 1'b1;
        inc0 = 16'h0005; inc1 = 16'h0006; inc2 = 16'h0007;
        u_val = 16'h3C00; init0 = 16'h0100; init1 = 16'h0200; init2 = 16'h0300;
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        repeat (EP + 2) begin
            @(posedge clk); #1;
        end
        total++;
        if ({bus_a.busy, bus_b.busy, bus_a.epoch_cnt, bus_a.in1, bus_a.in2, bus_a.d} !==
            {1'b1, 1'b1, 8'd1, 16'h0000, 16'h0000, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL reset_mid_pre got busy=%b%b ep=%0d in=%h/%h/%h want busy=11 ep=1 in=0/0/0",
                     bus_a.busy, bus_b.busy, bus_a.epoch_cnt, bus_a.in1, bus_a.in2, bus_a.d);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus_a.busy, bus_a.done, bus_a.converged, bus_a.epoch_cnt, bus_a.err_cnt,
             bus_a.w0, bus_a.w1, bus_a.w2, bus_a.u, bus_a.in1, bus_a.in2, bus_a.d} !== 126'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_a got busy=%b ep=%0d err=%0d w0=%h u=%h",
                     bus_a.busy, bus_a.epoch_cnt, bus_a.err_cnt, bus_a.w0, bus_a.u);
        end
        total++;
        if ({bus_b.busy, bus_b.done, bus_b.converged, bus_b.epoch_cnt, bus_b.err_cnt,
             bus_b.w0, bus_b.w1, bus_b.w2, bus_b.u, bus_b.in1, bus_b.in2, bus_b.d} !== 126'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_b got busy=%b ep=%0d err=%0d w0=%h u=%h",
                     bus_b.busy, bus_b.epoch_cnt, bus_b.err_cnt, bus_b.w0, bus_b.u);
        end
        reset = 1'b0;
        for (int k = 0; k < 3 * EP; k++) begin
            @(posedge clk); #1;
            total++;
            if ({bus_a.busy, bus_a.done, bus_b.busy, bus_b.done} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL reset_mid_quiet k=%0d got a=%b%b b=%b%b want 00 00",
                         k, bus_a.busy, bus_a.done, bus_b.busy, bus_b.done);
            end
        end
    endtask

    // start held high: ignored while busy, re-accepted from the IDLE after DONE
    task automatic test_back_to_back();
        logic eb, ed;
        logic [15:0] e1, e2, edd;
        int k2;
        clear_tab();
        inc0 = 16'h0001; inc1 = 16'h0001; inc2 = 16'h0001;
        u_val = 16'h3555; init0 = 16'h0A0A; init1 = 16'h0B0B; init2 = 16'h0C0C;
        drive_start(1'b1);
        @(posedge clk); #1;
        for (int k = 1; k <= 2 * (EP + 3) + 2; k++) begin
            k2 = (k <= EP + 3) ? k : k - (EP + 3);
            exp_cycle(k2, 1, eb, ed, e1, e2, edd);
            total++;
            if ({bus_a.busy, bus_a.done, bus_b.busy, bus_b.done} !== {eb, ed, eb, ed}) begin
                bad++;
                $display("[TB] FAIL back_to_back k=%0d got a=%b%b b=%b%b want %b%b",
                         k, bus_a.busy, bus_a.done, bus_b.busy, bus_b.done, eb, ed);
            end
            if (k == EP + 6) drive_start(1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        or_in1[0] = 16'h0000; or_in2[0] = 16'h0000; or_d[0] = 16'h0000;
        or_in1[1] = 16'h0000; or_in2[1] = 16'h3C00; or_d[1] = 16'h3C00;
        or_in1[2] = 16'h3C00; or_in2[2] = 16'h0000; or_d[2] = 16'h3C00;
        or_in1[3] = 16'h3C00; or_in2[3] = 16'h3C00; or_d[3] = 16'h3C00;
        inc0 = '0; inc1 = '0; inc2 = '0;
        clear_tab();
        @(posedge clk); #1;
        test_reset();
        test_converge_first();
        test_max_epochs();
        test_one_error();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
